factorial_cu: RTL and testbench
===============================

# factorial_cu

Control unit for the factorial engine. A Moore FSM sequences the factorial datapath (down-counter CNT, comparators, MUX2, REG, MUL, BUFFER) by driving its load, enable, select and output-enable strobes, and consumes its comparator flags `x_GT_1` and `x_GT_12`. It sits directly upstream of the datapath in the factorial top level. It also provides a go/done handshake with error reporting to the user side.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `go`  in  1  start request, level; must stay high until `done` or `err` is seen.
- `n`  in  4  operand; same bus that feeds the datapath counter; must be stable while `go` is high.
- `x_GT_1`  in  1  datapath flag: counter > 1.
- `x_GT_12`  in  1  datapath flag: counter > 12.
- `ld_CNT`  out  1  load counter with `n`.
- `en_CNT`  out  1  decrement counter by 1.
- `ld_REG`  out  1  load product register.
- `sel_MUX`  out  1  0 = register input is constant 1; 1 = register input is MUL output.
- `OE_BUF`  out  1  drive `product` from MUL output.
- `done`  out  1  result valid on `product`.
- `err`  out  1  operand out of range (n = 0 or n > 12).
- `cs`  out  3  current state code, for debug.

## Operation
- Moore FSM. All outputs decode from the state register only. No output depends combinationally on any input.
- IDLE (0): all strobes 0.
  - `go` & n==0 → ERR.
  - `go` & n≠0 → LOAD.
- LOAD (1): `ld_CNT`=1, `ld_REG`=1, `sel_MUX`=0. Sets CNT=n, REG=1. → CHECK.
- CHECK (2): all strobes 0.
  - `x_GT_12` → ERR.
  - else `x_GT_1` → MULT.
  - else → DONE.
- MULT (3): `ld_REG`=1, `sel_MUX`=1, `en_CNT`=1. Sets REG ← CNT·REG and CNT ← CNT−1 on the same edge. → CHECK.
- DONE (4): `OE_BUF`=1, `done`=1. With CNT=1, MUL output equals REG = n!.
  - `go` high → stay in DONE.
  - `go` low → IDLE.
- ERR (5): `err`=1, all strobes 0.
  - `go` high → stay in ERR.
  - `go` low → IDLE.
- Codes 6 and 7 are illegal and → IDLE on the next edge, with all outputs 0.
- Valid domain is 1..12. Largest result is 12! = 479001600, which fits in 32 bits. n = 0 and n ≥ 13 both end in ERR.
- `x_GT_12` is only consulted in CHECK. It can only be true on the first CHECK, because the counter only decrements after that.

## Timing
- Reset: state = IDLE. Every output is 0, including `cs` = 0.
- Reset mid-operation: on assertion, IDLE is entered immediately and strobes drop asynchronously. Datapath CNT/REG contents are don't-care afterwards.
- `go` is sampled on the rising edge in IDLE. The first strobe cycle (LOAD, or ERR when n = 0) starts one edge later.
- Latency from the `go`-sampling edge to the first `done` cycle is 2n+1 cycles:
  - 1 edge for LOAD.
  - 1 edge for the first CHECK.
  - 2 edges per multiply, n−1 multiplies.
  - 1 edge into DONE.
- Examples: n=1 → 3 cycles; n=5 → 11 cycles; n=12 → 25 cycles.
- Error latency:
  - n = 0: ERR 1 edge after the sampling edge.
  - n > 12: ERR 3 edges after the sampling edge.
- `done`/`err` stay high for as long as `go` stays high. After `go` falls they deassert 1 edge later, and IDLE is entered on that same edge.
- Restart: a new `go` is accepted no earlier than the edge after IDLE is re-entered. `go` held high continuously never produces a second run.
- `ld_CNT` and `en_CNT` are never high in the same cycle. `OE_BUF` is high only in DONE.

## Structure
- Shared package `factorial_pkg`:
  - state encoding constants `S_IDLE`..`S_ERR` (3-bit).
  - `N_MAX` = 12.
- Single flat module: one state register (async reset) plus next-state and output decode. No sub-module needed.
- The top-level `factorial` wires `factorial_cu` to `factorial_dp`. This block instantiates neither.

## Test plan
- n=5: pulse `go` high and hold. Closed-loop with `factorial_dp`.
  - Required: `done` 11 cycles after the sampling edge, `product` = 120, `OE_BUF`=1.
  - Drop `go` → IDLE next edge, `done`=0.
- n=1 and n=12, closed-loop.
  - n=1: `done` after 3 cycles, `product` = 1, zero MULT cycles.
  - n=12: `done` after 25 cycles, `product` = 479001600.
- Out-of-range operands.
  - n=0: `err`=1 one edge after sampling; no strobe is ever asserted.
  - n=13: `err`=1 after 3 edges; exactly one LOAD cycle and zero MULT cycles.
- Reset mid-run: n=9, assert `rst` during the 3rd MULT cycle.
  - Required: `cs`=0 and all outputs 0 immediately.
  - After release with `go` low: stays IDLE. A new n=3 run gives `product` = 6.
- Protocol checks.
  - Hold `go` high through DONE for 20 cycles: `done` stays 1 and no new LOAD occurs.
  - Force `cs`=7 through the debug backdoor: IDLE next edge.
  - Over every run: `ld_CNT`&`en_CNT` is never 1.

Source files
------------

// File: rtl/factorial_pkg.sv
// rtl/factorial_pkg.sv - shared state encoding and strobe bundle for the factorial engine
package factorial_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_MULT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam int N_MAX = 12;

    typedef struct packed {
        logic ld_cnt;
        logic en_cnt;
        logic ld_reg;
        logic sel_mux;
        logic oe_buf;
        logic done;
        logic err;
    } ctrl_t;

    // Moore output decode; illegal codes fall through to all-zero.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_LOAD: begin
                c.ld_cnt = 1'b1;
                c.ld_reg = 1'b1;
            end
            S_MULT: begin
                c.ld_reg  = 1'b1;
                c.sel_mux = 1'b1;
                c.en_cnt  = 1'b1;
            end
            S_DONE: begin
                c.oe_buf = 1'b1;
                c.done   = 1'b1;
            end
            S_ERR:   c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/factorial_cu.sv
// rtl/factorial_cu.sv - Moore control unit sequencing the factorial datapath
module factorial_cu
    import factorial_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [3:0] n,
    input  logic       x_GT_1,
    input  logic       x_GT_12,
    output logic       ld_CNT,
    output logic       en_CNT,
    output logic       ld_REG,
    output logic       sel_MUX,
    output logic       OE_BUF,
    output logic       done,
    output logic       err,
    output logic [2:0] cs
);

    state_t state;
    state_t nxt;
    ctrl_t  ctrl;

    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:  nxt = !go ? S_IDLE : ((n == 4'd0) ? S_ERR : S_LOAD);
            S_LOAD:  nxt = S_CHECK;
            S_CHECK: nxt = x_GT_12 ? S_ERR : (x_GT_1 ? S_MULT : S_DONE);
            S_MULT:  nxt = S_CHECK;
            S_DONE:  nxt = go ? S_DONE : S_IDLE;
            S_ERR:   nxt = go ? S_ERR : S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ctrl  <= '0;
        end else begin
            state <= nxt;
            ctrl  <= decode(nxt);
        end
    end

    assign ld_CNT  = ctrl.ld_cnt;
    assign en_CNT  = ctrl.en_cnt;
    assign ld_REG  = ctrl.ld_reg;
    assign sel_MUX = ctrl.sel_mux;
    assign OE_BUF  = ctrl.oe_buf;
    assign done    = ctrl.done;
    assign err     = ctrl.err;
    assign cs      = state;

endmodule

// File: tb/tb_factorial_cu.sv
// tb/tb_factorial_cu.sv - closed-loop randomized bench for factorial_cu with a datapath model
module tb_factorial_cu;
    import factorial_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go  = 1'b0;
    logic [3:0]  n   = 4'd0;
    logic        x_GT_1, x_GT_12;
    logic        ld_CNT, en_CNT, ld_REG, sel_MUX, OE_BUF, done, err;
    logic [2:0]  cs;

    logic [3:0]  dp_cnt;
    logic [31:0] dp_reg;
    logic [31:0] product;

    int errors = 0;
    int checks = 0;

    factorial_cu dut (
        .clk(clk), .rst(rst), .go(go), .n(n),
        .x_GT_1(x_GT_1), .x_GT_12(x_GT_12),
        .ld_CNT(ld_CNT), .en_CNT(en_CNT), .ld_REG(ld_REG), .sel_MUX(sel_MUX),
        .OE_BUF(OE_BUF), .done(done), .err(err), .cs(cs)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: counter, product register, multiplier, output buffer.
    assign x_GT_1  = dp_cnt > 4'd1;
    assign x_GT_12 = dp_cnt > 4'd12;
    assign product = OE_BUF ? (32'(dp_cnt) * dp_reg) : 32'd0;

    always @(posedge clk) begin
        if (ld_CNT)      dp_cnt <= n;
        else if (en_CNT) dp_cnt <= dp_cnt - 4'd1;
        if (ld_REG)      dp_reg <= sel_MUX ? 32'(dp_cnt) * dp_reg : 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fact(input int k);
        logic [31:0] f = 32'd1;
        for (int i = 2; i <= k; i++) f = f * 32'(i);
        return f;
    endfunction

    // One go/done transaction; hold = extra cycles go stays high after done/err.
    task automatic run(input int nv, input int hold);
        int lat, loads, mults, both, hold_loads, hold_lost;
        bit in_range, finished;
        in_range = (nv >= 1) && (nv <= N_MAX);
        lat = 0; loads = 0; mults = 0; both = 0; finished = 0;
        @(negedge clk);
        n  = 4'(nv);
        go = 1'b1;
        for (int e = 0; e < 60 && !finished; e++) begin
            @(posedge clk); #1;
            lat++;
            if (ld_CNT) loads++;
            if (en_CNT) mults++;
            if (ld_CNT && en_CNT) both++;
            if (OE_BUF && !done) both++;
            if (done || err) finished = 1;
        end
        check($sformatf("finished n=%0d", nv), 32'(finished), 32'd1);
        if (nv == 0) begin
            check($sformatf("err_lat n=%0d", nv), 32'(lat), 32'd1);
            check($sformatf("no_strobe n=%0d", nv), 32'(loads + mults), 32'd0);
        end else if (!in_range) begin
            check($sformatf("err_lat n=%0d", nv), 32'(lat), 32'd3);
            check($sformatf("loads n=%0d", nv), 32'(loads), 32'd1);
            check($sformatf("mults n=%0d", nv), 32'(mults), 32'd0);
        end else begin
            check($sformatf("done_lat n=%0d", nv), 32'(lat), 32'(2 * nv + 1));
            check($sformatf("product n=%0d", nv), product, fact(nv));
            check($sformatf("mults n=%0d", nv), 32'(mults), 32'(nv - 1));
            check($sformatf("oe n=%0d", nv), 32'(OE_BUF), 32'd1);
        end
        check($sformatf("flags n=%0d", nv), {30'd0, done, err}, in_range ? 32'd2 : 32'd1);
        check($sformatf("cs_end n=%0d", nv), 32'(cs), in_range ? 32'd4 : 32'd5);
        hold_loads = 0; hold_lost = 0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (ld_CNT || en_CNT) hold_loads++;
            if (!(done || err)) hold_lost++;
        end
        if (hold > 0) begin
            check($sformatf("hold_nostart n=%0d", nv), 32'(hold_loads), 32'd0);
            check($sformatf("hold_flag n=%0d", nv), 32'(hold_lost), 32'd0);
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk); #1;
        check($sformatf("release n=%0d", nv), {28'd0, cs, done | err}, 32'd0);
        check($sformatf("ld_en_excl n=%0d", nv), 32'(both), 32'd0);
    endtask

    initial begin
        int m;
        #12;
        check("reset_outputs", {22'd0, ld_CNT, en_CNT, ld_REG, sel_MUX, OE_BUF, done, err, cs}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(5, 0);
        run(1, 0);
        run(12, 20);
        run(0, 2);
        run(13, 0);
        for (int r = 0; r < 16; r++) run(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

        // Reset during the third multiply of n=9.
        @(negedge clk);
        n = 4'd9; go = 1'b1;
        m = 0;
        for (int e = 0; e < 40 && m < 3; e++) begin
            @(posedge clk); #1;
            if (en_CNT) m++;
        end
        check("mid_mult_reached", 32'(m), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("async_reset", {22'd0, ld_CNT, en_CNT, ld_REG, sel_MUX, OE_BUF, done, err, cs}, 32'd0);
        go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {28'd0, cs, ld_CNT}, 32'd0);
        run(3, 0);

        // Illegal state code recovers to IDLE on the next edge.
        @(negedge clk);
        force dut.state = state_t'(3'd7);
        #1 release dut.state;
        #1;
        check("illegal_cs", 32'(cs), 32'd7);
        @(posedge clk); #1;
        check("illegal_recover", {22'd0, ld_CNT, en_CNT, ld_REG, sel_MUX, OE_BUF, done, err, cs}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
